// File: rtl/pmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pmp_pkg
// Description : Shared PMP encodings (cfg fields, access types, privilege).
// Revision    : 1.0 - initial release
// ============================================================================
package pmp_pkg;

    localparam int XLEN      = 32;
    localparam int PADDR_LEN = 34;

    // pmpcfg A-field encodings
    localparam logic [1:0] A_OFF   = 2'd0;
    localparam logic [1:0] A_TOR   = 2'd1;
    localparam logic [1:0] A_NA4   = 2'd2;
    localparam logic [1:0] A_NAPOT = 2'd3;

    // pmpcfg bit positions
    localparam int CFG_R    = 0;
    localparam int CFG_W    = 1;
    localparam int CFG_X    = 2;
    localparam int CFG_A_LO = 3;
    localparam int CFG_A_HI = 4;
    localparam int CFG_L    = 7;

    typedef enum logic [1:0] {
        ACC_READ  = 2'd0,
        ACC_WRITE = 2'd1,
        ACC_EXEC  = 2'd2,
        ACC_RSVD  = 2'd3
    } acc_type_e;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } acc_size_e;

    localparam logic [1:0] PRV_U = 2'd0;
    localparam logic [1:0] PRV_S = 2'd1;
    localparam logic [1:0] PRV_M = 2'd3;

    // Last byte of an access; the MSB is the carry out of the physical space.
    function automatic logic [PADDR_LEN:0] last_addr(input logic [PADDR_LEN-1:0] addr,
                                                      input logic [1:0]           size);
        logic [PADDR_LEN:0] inc;
        inc       = '0;
        inc[size] = 1'b1;
        return {1'b0, addr} + inc - (PADDR_LEN+1)'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pmp_entry_match.sv
`default_nettype none
// ============================================================================
// Module      : pmp_entry_match
// Description : Combinational address/permission match of one PMP entry.
// Revision    : 1.0 - initial release
// ============================================================================
module pmp_entry_match
    import pmp_pkg::*;
(
    input  logic [7:0]           cfg,
    input  logic [XLEN-1:0]      addr,
    input  logic [XLEN-1:0]      prev_addr,
    input  logic [PADDR_LEN-1:0] acc_first,
    input  logic [PADDR_LEN-1:0] acc_last,
    input  logic                 is_entry0,
    input  logic [1:0]           acc_type,
    output logic                 full,
    output logic                 partial,
    output logic                 perm_ok
);

    localparam logic [PADDR_LEN-1:0] C_ONE = PADDR_LEN'(1);

    logic [PADDR_LEN-1:0] w_base;
    logic [PADDR_LEN-1:0] w_lo;
    logic [PADDR_LEN-1:0] w_napot_y;
    logic [PADDR_LEN-1:0] w_napot_mask;
    logic [1:0]           w_a;
    logic                 w_m_first;
    logic                 w_m_last;
    logic                 w_unused_cfg;

    assign w_a       = cfg[CFG_A_HI:CFG_A_LO];
    assign w_base    = {addr[PADDR_LEN-3:0], 2'b00};
    assign w_lo      = is_entry0 ? '0 : {prev_addr[PADDR_LEN-3:0], 2'b00};
    // y ^ (y+1) yields ones in the low t+3 bits; wraps to all-ones for full space
    assign w_napot_y    = {addr[PADDR_LEN-3:0], 2'b11};
    assign w_napot_mask = w_napot_y ^ (w_napot_y + C_ONE);

    assign w_unused_cfg = &{cfg[7:5], addr[XLEN-1:PADDR_LEN-2], prev_addr[XLEN-1:PADDR_LEN-2]};

    function automatic logic byte_match(input logic [1:0]           a,
                                        input logic [PADDR_LEN-1:0] b,
                                        input logic [PADDR_LEN-1:0] lo,
                                        input logic [PADDR_LEN-1:0] base,
                                        input logic [PADDR_LEN-1:0] mask);
        logic m;
        case (a)
            A_TOR:   m = (b >= lo) && (b < base);
            A_NA4:   m = (b[PADDR_LEN-1:2] == base[PADDR_LEN-1:2]);
            A_NAPOT: m = ((b & ~mask) == (base & ~mask));
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    assign w_m_first = byte_match(w_a, acc_first, w_lo, w_base, w_napot_mask);
    assign w_m_last  = byte_match(w_a, acc_last,  w_lo, w_base, w_napot_mask);

    assign full    = w_m_first & w_m_last;
    assign partial = w_m_first ^ w_m_last;

    always_comb begin
        perm_ok = cfg[CFG_R];
        case (acc_type)
            ACC_WRITE: perm_ok = cfg[CFG_W];
            ACC_EXEC:  perm_ok = cfg[CFG_X];
            default:   perm_ok = cfg[CFG_R];
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pmp_chk.sv
`default_nettype none
// ============================================================================
// Module      : pmp_chk
// Description : Multi-cycle PMP checker scanning GRP entries per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module pmp_chk
    import pmp_pkg::*;
#(
    parameter int NUM_ENTRY = 16,
    parameter int GRP       = 4
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [NUM_ENTRY-1:0][7:0]           pmpcfg,
    input  logic [NUM_ENTRY-1:0][XLEN-1:0]      pmpaddr,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [PADDR_LEN-1:0]                req_addr,
    input  logic [1:0]                          req_size,
    input  logic [1:0]                          req_type,
    input  logic [1:0]                          req_prv,
    output logic                                resp_valid,
    input  logic                                resp_ready,
    output logic                                resp_fault,
    output logic                                resp_hit,
    output logic [$clog2(NUM_ENTRY)-1:0]        resp_idx,
    output logic                                busy
);

    localparam int IDXW = $clog2(NUM_ENTRY);
    localparam int NGRP = NUM_ENTRY / GRP;
    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e               r_state;
    logic [PADDR_LEN-1:0] r_first;
    logic [PADDR_LEN-1:0] r_last;
    logic                 r_carry;
    logic [1:0]           r_type;
    logic [1:0]           r_prv;
    logic [GW-1:0]        r_grp;

    logic [PADDR_LEN:0]   w_last;
    logic [IDXW-1:0]      w_idx [GRP];
    logic [GRP-1:0]       w_full;
    logic [GRP-1:0]       w_part;
    logic [GRP-1:0]       w_perm;

    logic                 w_any;
    logic                 w_sel_part;
    logic                 w_sel_perm;
    logic                 w_sel_lock;
    logic [IDXW-1:0]      w_sel_idx;
    logic                 w_hit_fault;

    assign w_last = last_addr(req_addr, req_size);

    generate
        for (genvar k = 0; k < GRP; k++) begin : g_ent
            logic [IDXW-1:0] w_prev_idx;
            assign w_idx[k]   = IDXW'(r_grp) * IDXW'(GRP) + IDXW'(k);
            assign w_prev_idx = w_idx[k] - IDXW'(1);

            pmp_entry_match u_match (
                .cfg       (pmpcfg[w_idx[k]]),
                .addr      (pmpaddr[w_idx[k]]),
                .prev_addr (pmpaddr[w_prev_idx]),
                .acc_first (r_first),
                .acc_last  (r_last),
                .is_entry0 (w_idx[k] == '0),
                .acc_type  (r_type),
                .full      (w_full[k]),
                .partial   (w_part[k]),
                .perm_ok   (w_perm[k])
            );
        end
    endgenerate

    // Descending walk so the lowest-numbered matching entry is the last written
    always_comb begin
        w_any      = 1'b0;
        w_sel_part = 1'b0;
        w_sel_perm = 1'b0;
        w_sel_lock = 1'b0;
        w_sel_idx  = '0;
        for (int k = GRP - 1; k >= 0; k--) begin
            if (w_full[k] || w_part[k]) begin
                w_any      = 1'b1;
                w_sel_part = w_part[k];
                w_sel_perm = w_perm[k];
                w_sel_lock = pmpcfg[w_idx[k]][CFG_L];
                w_sel_idx  = w_idx[k];
            end
        end
    end

    always_comb begin
        if (w_sel_part)
            w_hit_fault = 1'b1;
        else if (r_prv != PRV_M)
            w_hit_fault = ~w_sel_perm;
        else
            w_hit_fault = w_sel_lock & ~w_sel_perm;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_first    <= '0;
            r_last     <= '0;
            r_carry    <= 1'b0;
            r_type     <= ACC_READ;
            r_prv      <= PRV_U;
            r_grp      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_hit   <= 1'b0;
            resp_idx   <= '0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        r_first   <= req_addr;
                        r_last    <= w_last[PADDR_LEN-1:0];
                        r_carry   <= w_last[PADDR_LEN];
                        r_type    <= (req_type == ACC_RSVD) ? ACC_READ : req_type;
                        r_prv     <= req_prv;
                        r_grp     <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (r_carry) begin
                        resp_fault <= 1'b1;
                        resp_hit   <= 1'b0;
                        resp_idx   <= '0;
                        resp_valid <= 1'b1;
                        r_state    <= S_RESP;
                    end else if (w_any) begin
                        resp_fault <= w_hit_fault;
                        resp_hit   <= 1'b1;
                        resp_idx   <= w_sel_idx;
                        resp_valid <= 1'b1;
                        r_state    <= S_RESP;
                    end else if (r_grp == GW'(NGRP - 1)) begin
                        resp_fault <= (r_prv != PRV_M);
                        resp_hit   <= 1'b0;
                        resp_idx   <= '0;
                        resp_valid <= 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        r_grp <= r_grp + GW'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pmp_chk.sv
`default_nettype none
// ============================================================================
// Module      : tb_pmp_chk
// Description : Self-checking bench for pmp_chk (directed table + random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pmp_chk;
    import pmp_pkg::*;

    localparam int NE = 16;

    logic                       clk  = 1'b0;
    logic                       rstn = 1'b0;
    logic [NE-1:0][7:0]         pmpcfg;
    logic [NE-1:0][XLEN-1:0]    pmpaddr;
    logic                       req_valid;
    logic                       req_ready;
    logic [PADDR_LEN-1:0]       req_addr;
    logic [1:0]                 req_size;
    logic [1:0]                 req_type;
    logic [1:0]                 req_prv;
    logic                       resp_valid;
    logic                       resp_ready;
    logic                       resp_fault;
    logic                       resp_hit;
    logic [3:0]                 resp_idx;
    logic                       busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pmp_chk #(.NUM_ENTRY(16), .GRP(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .pmpcfg     (pmpcfg),
        .pmpaddr    (pmpaddr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_type   (req_type),
        .req_prv    (req_prv),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_fault (resp_fault),
        .resp_hit   (resp_hit),
        .resp_idx   (resp_idx),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: regions as plain byte ranges
    function automatic bit ref_match(input int i, input longint b);
        longint pa, lo, sz, base;
        int     t;
        pa = longint'({32'b0, pmpaddr[i]});
        case (pmpcfg[i][4:3])
            2'd1: begin
                lo = (i == 0) ? 0 : longint'({32'b0, pmpaddr[i-1]}) * 4;
                return (b >= lo) && (b < pa * 4);
            end
            2'd2: return (b / 4) == pa;
            2'd3: begin
                t = 0;
                while (t < 32 && pmpaddr[i][t]) t++;
                sz   = longint'(1) << (t + 3);
                base = ((pa * 4) / sz) * sz;
                return (b >= base) && (b < base + sz);
            end
            default: return 1'b0;
        endcase
    endfunction

    task automatic ref_model(input longint a, input int sz, input int typ, input int prv,
                             output bit f, output bit h, output int idx, output int lat);
        longint la;
        bit     m0, m1, perm;
        la  = a + (longint'(1) << sz) - 1;
        f   = (prv != 3);
        h   = 1'b0;
        idx = 0;
        lat = 4;
        if (la >= (longint'(1) << PADDR_LEN)) begin
            f   = 1'b1;
            lat = 1;
            return;
        end
        for (int i = 0; i < NE; i++) begin
            m0 = ref_match(i, a);
            m1 = ref_match(i, la);
            if (m0 || m1) begin
                perm = (typ == 1) ? pmpcfg[i][1] : (typ == 2) ? pmpcfg[i][2] : pmpcfg[i][0];
                h    = 1'b1;
                idx  = i;
                lat  = i / 4 + 1;
                if (m0 != m1)      f = 1'b1;
                else if (prv != 3) f = !perm;
                else               f = pmpcfg[i][7] & !perm;
                return;
            end
        end
    endtask

    task automatic do_req(input logic [33:0] a, input int sz, input int typ, input int prv,
                          output bit f, output bit h, output int idx, output int lat);
        int guard;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!req_ready) chk("req_ready_timeout", 0, 1);
        req_addr  = a;
        req_size  = 2'(sz);
        req_type  = 2'(typ);
        req_prv   = 2'(prv);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!resp_valid) chk("resp_timeout", 0, 1);
        f   = resp_fault;
        h   = resp_hit;
        idx = int'(resp_idx);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    typedef struct {
        int          na;
        int          ia;  logic [7:0] ca;  logic [31:0] aa;
        int          ib;  logic [7:0] cb;  logic [31:0] ab;
        logic [33:0] addr;
        int          size, typ, prv;
        bit          f, h;
        int          idx, lat;
    } vec_t;

    vec_t tbl [14];

    task automatic clear_entries();
        pmpcfg  = '0;
        pmpaddr = '0;
    endtask

    initial begin
        bit f, h, ef, eh;
        int idx, lat, eidx, elat, prv, t;
        logic [33:0] ra;
        logic [31:0] base;
        logic [1:0]  am;

        //          na ia ca     aa            ib cb     ab            addr            sz ty pv f h idx lat
        tbl[0]  = '{1, 0, 8'h1B, 32'h2000_01FF, 0, 8'h00, 32'h0,        34'h0_8000_0FFC, 2, 0, 1, 0,1, 0, 1};
        tbl[1]  = '{1, 0, 8'h1B, 32'h2000_01FF, 0, 8'h00, 32'h0,        34'h0_8000_0FFC, 3, 0, 1, 1,1, 0, 1};
        tbl[2]  = '{2, 3, 8'h00, 32'h2000_0000, 4, 8'h09, 32'h2000_0400, 34'h0_8000_0100, 2, 1, 0, 1,1, 4, 2};
        tbl[3]  = '{2, 2, 8'h10, 32'h2000_0004, 9, 8'h17, 32'h2000_0004, 34'h0_8000_0010, 2, 0, 1, 1,1, 2, 1};
        tbl[4]  = '{1,15, 8'h98, 32'hFFFF_FFFF, 0, 8'h00, 32'h0,        34'h0_0000_0000, 2, 2, 3, 1,1,15, 4};
        tbl[5]  = '{1,15, 8'h18, 32'hFFFF_FFFF, 0, 8'h00, 32'h0,        34'h0_0000_0000, 2, 2, 3, 0,1,15, 4};
        tbl[6]  = '{0, 0, 8'h00, 32'h0,         0, 8'h00, 32'h0,        34'h0_8000_0000, 2, 0, 3, 0,0, 0, 4};
        tbl[7]  = '{0, 0, 8'h00, 32'h0,         0, 8'h00, 32'h0,        34'h0_8000_0000, 2, 0, 0, 1,0, 0, 4};
        tbl[8]  = '{0, 0, 8'h00, 32'h0,         0, 8'h00, 32'h0,        34'h3_FFFF_FFFE, 2, 0, 3, 1,0, 0, 1};
        tbl[9]  = '{1, 0, 8'h09, 32'h0000_0100, 0, 8'h00, 32'h0,        34'h0_0000_0000, 3, 0, 0, 0,1, 0, 1};
        tbl[10] = '{1, 0, 8'h09, 32'h0000_0100, 0, 8'h00, 32'h0,        34'h0_0000_0000, 3, 3, 0, 0,1, 0, 1};
        tbl[11] = '{1, 5, 8'h12, 32'h2000_0004, 0, 8'h00, 32'h0,        34'h0_8000_0012, 1, 1, 1, 0,1, 5, 2};
        tbl[12] = '{1, 0, 8'h0F, 32'h2000_0040, 0, 8'h00, 32'h0,        34'h0_8000_00FC, 2, 0, 0, 0,1, 0, 1};
        tbl[13] = '{1, 0, 8'h0F, 32'h2000_0040, 0, 8'h00, 32'h0,        34'h0_8000_00FE, 2, 0, 0, 1,1, 0, 1};

        clear_entries();
        req_valid  = 1'b0;
        req_addr   = '0;
        req_size   = '0;
        req_type   = '0;
        req_prv    = '0;
        resp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready",  req_ready,  1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_fault", resp_fault, 0);
        chk("rst_resp_hit",   resp_hit,   0);
        chk("rst_resp_idx",   resp_idx,   0);
        chk("rst_busy",       busy,       0);
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 14; v++) begin
            clear_entries();
            if (tbl[v].na > 0) begin pmpcfg[tbl[v].ia] = tbl[v].ca; pmpaddr[tbl[v].ia] = tbl[v].aa; end
            if (tbl[v].na > 1) begin pmpcfg[tbl[v].ib] = tbl[v].cb; pmpaddr[tbl[v].ib] = tbl[v].ab; end
            do_req(tbl[v].addr, tbl[v].size, tbl[v].typ, tbl[v].prv, f, h, idx, lat);
            chk($sformatf("vec%0d_fault", v), f,   tbl[v].f);
            chk($sformatf("vec%0d_hit", v),   h,   tbl[v].h);
            chk($sformatf("vec%0d_idx", v),   idx, tbl[v].idx);
            chk($sformatf("vec%0d_lat", v),   lat, tbl[v].lat);
        end

        // Response held while resp_ready is low
        clear_entries();
        pmpcfg[0]  = 8'h1B;
        pmpaddr[0] = 32'h2000_01FF;
        req_addr = 34'h0_8000_0FFC; req_size = 2'd2; req_type = 2'd0; req_prv = 2'd1;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("hold_first_valid", resp_valid, 1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d_valid", c), resp_valid, 1);
            chk($sformatf("hold%0d_fault", c), resp_fault, 0);
            chk($sformatf("hold%0d_hit", c),   resp_hit,   1);
            chk($sformatf("hold%0d_idx", c),   resp_idx,   0);
            chk($sformatf("hold%0d_ready", c), req_ready,  0);
            chk($sformatf("hold%0d_busy", c),  busy,       1);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("hold_release_ready", req_ready, 1);
        chk("hold_release_busy",  busy,      0);

        // Async reset in the middle of a 4-group scan
        clear_entries();
        req_addr = 34'h0; req_size = 2'd2; req_type = 2'd0; req_prv = 2'd3;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("scan_busy",      busy,      1);
        chk("scan_req_ready", req_ready, 0);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("arst_resp_valid", resp_valid, 0);
        chk("arst_req_ready",  req_ready,  1);
        chk("arst_busy",       busy,       0);
        #2;
        rstn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk($sformatf("arst_stale%0d", c), resp_valid, 0);
        end
        do_req(34'h0, 2, 0, 0, f, h, idx, lat);
        chk("post_rst_fault", f,   1);
        chk("post_rst_lat",   lat, 4);

        // Randomized against the reference model
        for (int r = 0; r < 400; r++) begin
            if (r % 8 == 0) begin
                for (int i = 0; i < NE; i++) begin
                    am   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
                    base = 32'h2000_0000 + $urandom_range(0, 511);
                    pmpcfg[i] = {1'($urandom_range(0, 1)), 2'b00, am, 3'($urandom_range(0, 7))};
                    if (am == 2'd3) begin
                        t = $urandom_range(0, 7);
                        pmpaddr[i] = (base & ~((32'd1 << (t + 1)) - 1)) | ((32'd1 << t) - 1);
                        if ($urandom_range(0, 40) == 0) pmpaddr[i] = 32'hFFFF_FFFF;
                    end else begin
                        pmpaddr[i] = base;
                    end
                end
            end
            if ($urandom_range(0, 19) == 0)
                ra = 34'h3_FFFF_FFF8 + 34'($urandom_range(0, 7));
            else
                ra = 34'h0_8000_0000 + 34'($urandom_range(0, 4095));
            case ($urandom_range(0, 2))
                0:       prv = 0;
                1:       prv = 1;
                default: prv = 3;
            endcase
            t = $urandom_range(0, 3);
            idx = $urandom_range(0, 3);
            ref_model(longint'({30'b0, ra}), t, idx, prv, ef, eh, eidx, elat);
            do_req(ra, t, idx, prv, f, h, idx, lat);
            chk($sformatf("rnd%0d_fault", r), f,   ef);
            chk($sformatf("rnd%0d_hit", r),   h,   eh);
            chk($sformatf("rnd%0d_idx", r),   idx, eidx);
            chk($sformatf("rnd%0d_lat", r),   lat, elat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pmp_chk.md
Name:
pmp_chk

Overview:
- Consumer side of the PMP CSR interface: takes the live pmpcfg/pmpaddr arrays from the CSR block and checks each physical access against them.
- Sits between the MMU/LSU/IFU request path and the bus.
- Scans the 16 entries in groups over several cycles, lowest-numbered match wins, returns allow/fault and the matching entry index.
- Drives a busy flag that the CSR write path uses to stall pmpcfg/pmpaddr writes while a scan is in progress.

Parameters:
- NUM_ENTRY, 16, number of PMP entries; must equal the CSR block's entry count.
- GRP, 4, entries evaluated per scan cycle; must divide NUM_ENTRY. Scan length NGRP = NUM_ENTRY/GRP.

Ports:
- clk  in  1  core clock.
- rstn  in  1  asynchronous active-low reset.
- pmpcfg  in  8 x16  per-entry {L,2'b0,A[1:0],X,W,R}.
- pmpaddr  in  XLEN x16  physical address bits [PADDR_LEN-1:2] in bits [PADDR_LEN-3:0].
- req_valid  in  1  check request.
- req_ready  out  1  checker idle, request accepted when valid&ready.
- req_addr  in  PADDR_LEN  first byte address.
- req_size  in  2  0=byte, 1=half, 2=word, 3=dword.
- req_type  in  2  0=read, 1=write, 2=execute; 3 is reserved and treated as read.
- req_prv  in  2  privilege: 0=U, 1=S, 3=M.
- resp_valid  out  1  result available.
- resp_ready  in  1  result consumed.
- resp_fault  out  1  access denied.
- resp_hit  out  1  some entry matched.
- resp_idx  out  4  index of the matching entry; 0 when resp_hit=0.
- busy  out  1  high in SCAN and RESP; CSR writes to 0x3A0-0x3BF must stall while it is high.

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_fault=0, resp_hit=0, resp_idx=0, busy=0. The state machine returns to IDLE.
- Async reset mid-scan drops the request. No response is produced for it.
- FSM states are IDLE, SCAN and RESP.
  - IDLE: req_ready=1. On valid&ready, latch addr, last address la = addr + (1<<size) - 1, type and prv. Set group counter g=0 and go to SCAN.
  - SCAN: evaluate entries g*GRP .. g*GRP+GRP-1 combinationally from the live inputs.
    - If any entry in the group matches (full or partial), take the lowest such entry and go to RESP.
    - Otherwise, if g == NGRP-1, go to RESP with no hit. Else g++.
  - RESP: resp_valid=1 and outputs held stable until resp_ready, then go to IDLE. One-cycle bubble; no request is accepted in the same cycle.
- Latency from the accept edge to resp_valid is (matching group index + 1) cycles; minimum 1, maximum NGRP (4).
- Address match for entry i, by A:
  - A=0 (OFF): never matches.
  - A=1 (TOR): lower bound lo = (i==0) ? 0 : pmpaddr[i-1]<<2, upper bound hi = pmpaddr[i]<<2. A byte b matches when lo <= b < hi. lo >= hi never matches.
  - A=2 (NA4): b[PADDR_LEN-1:2] == pmpaddr[i][PADDR_LEN-3:0].
  - A=3 (NAPOT): t = number of trailing ones of pmpaddr[i]; region size is 2^(t+3) bytes. Compare b and pmpaddr<<2 with the low t+3 bits masked off. All-ones pmpaddr[i][PADDR_LEN-3:0] covers the whole physical space.
  - TOR comparisons use full PADDR_LEN unsigned width; no wrap.
- For each entry: full match = addr and la both match; partial match = exactly one of them matches.
- Permission result:
  - Partial match: fault=1, hit=1, regardless of mode or L.
  - Full match, prv != M: fault = !(perm bit for type). R for read, W for write, X for execute.
  - Full match, prv == M: fault = L & !(perm bit).
  - No match: fault = (prv != M).
- la crossing the top of the physical space (carry out) is a fault with hit=0.
- The latched request is not affected by pmpcfg/pmpaddr changes, but entries are read live. Correctness relies on busy stalling CSR writes.

Decomposition:
- Shared package pmp_pkg:
  - A-field encodings OFF/TOR/NA4/NAPOT and L/X/W/R bit positions, reused by the CSR block.
  - Access-type and size encodings.
  - Privilege encodings.
- One sub-module pmp_entry_match: pure combinational. Inputs are cfg, addr, prev_addr, the two access addresses and is_entry0. Outputs are full, partial and perm_ok. The top instantiates GRP copies selected by g.

Test Plan:
- NAPOT 4 KiB: entry0 pmpaddr=0x2000_01FF, cfg=0x1B (NAPOT,R,W,X); S-mode word read at 0x8000_0FFC -> resp_hit=1, idx=0, fault=0, resp_valid 1 cycle after accept.
- Straddle: same entry0, S-mode dword read at 0x8000_0FFC -> partial match, fault=1, idx=0.
- TOR at group boundary: entry3 pmpaddr=0x2000_0000 (OFF), entry4 TOR pmpaddr=0x2000_0400, cfg=0x09 (R); U-mode write at 0x8000_0100 -> hit=1, idx=4, fault=1, latency 2 cycles.
- Priority: entries 2 and 9 both NA4 on 0x8000_0010; entry2 no perms, entry9 RWX; S-mode read -> idx=2, fault=1.
- M-mode lock: entry15 NAPOT all-ones, cfg=0x98 (L,NAPOT, no RWX); M-mode execute at 0x0 -> fault=1, idx=15, latency 4 cycles. Same with cfg=0x18 -> fault=0. No entries enabled: M read -> fault=0, hit=0; U read -> fault=1.
- Handshake/reset: hold resp_ready=0 for 5 cycles -> outputs stable, req_ready=0, busy=1. Assert rstn=0 during SCAN -> resp_valid=0 and req_ready=1 immediately, no stale response after release.
